// File: rtl/spi_slave.sv
// SPI mode-0 style slave, LSB first, with synchronized SCLK/CS/MOSI and a load-able transmit buffer.
// Define SPI_SLAVE_MISO_TRISTATE_EN to float MISO when deselected or idle (otherwise it drives 0).
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [DATA_WIDTH-1:0] slaveDataToSend,
  input  logic                  load,
  output logic [DATA_WIDTH-1:0] slaveDataReceived,
  output logic                  rxValid,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   cs_prev;

  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_fall;
  logic                   cs_fall;
  logic                   cs_rise;

  logic [1:0]             state;
  logic [CW-1:0]          bit_count;
  logic [DATA_WIDTH-1:0]  tx_buf;
  logic [DATA_WIDTH-1:0]  tx_shift;
  logic [DATA_WIDTH-1:0]  rx_shift;
  logic                   miso_drive;

  // Synchronizers reset to the idle bus levels so releasing reset never fakes an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_fall = sclk_prev & ~sclk_s;
  assign cs_fall   = cs_prev & ~cs_s;
  assign cs_rise   = ~cs_prev & cs_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      bit_count         <= '0;
      tx_buf            <= '0;
      tx_shift          <= '0;
      rx_shift          <= '0;
      slaveDataReceived <= '0;
      rxValid           <= 1'b0;
    end else begin
      rxValid <= 1'b0;
      if (load) begin
        tx_buf <= slaveDataToSend;
      end
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state     <= SHIFT;
            tx_shift  <= load ? slaveDataToSend : tx_buf;
            rx_shift  <= '0;
            bit_count <= '0;
          end
        end
        SHIFT: begin
          // Abort wins; the completion check runs one cycle after the last shift.
          if (cs_rise) begin
            state <= IDLE;
          end else if (bit_count == CW'(DATA_WIDTH)) begin
            state             <= DONE;
            slaveDataReceived <= rx_shift;
            rxValid           <= 1'b1;
          end else if (sclk_fall) begin
            rx_shift  <= {mosi_s, rx_shift[DATA_WIDTH-1:1]};
            tx_shift  <= tx_shift >> 1;
            bit_count <= bit_count + CW'(1);
          end
        end
        DONE: begin
          if (cs_rise) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign miso_drive = (state != IDLE) && !cs_s;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign MISO = miso_drive ? tx_shift[0] : 1'bz;
`else
  assign MISO = miso_drive ? tx_shift[0] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: full, aborted, reloaded, back-to-back and reset-interrupted frames.
// Build with SPI_SLAVE_MISO_TRISTATE_EN defined to expect a floating MISO while deselected.
module tb_spi_slave;

  localparam int HALF = 6;

  logic       clk;
  logic       reset;
  logic       SCLK;
  logic       CS;
  logic       MOSI;
  logic       MISO;
  logic [7:0] slaveDataToSend;
  logic       load;
  logic [7:0] slaveDataReceived;
  logic       rxValid;
  logic       busy;

  int vectors_applied = 0;
  int miscompares     = 0;
  int rx_pulses       = 0;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  localparam logic MISO_IDLE = 1'bz;
`else
  localparam logic MISO_IDLE = 1'b0;
`endif

  spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .SCLK              (SCLK),
    .CS                (CS),
    .MOSI              (MOSI),
    .MISO              (MISO),
    .slaveDataToSend   (slaveDataToSend),
    .load              (load),
    .slaveDataReceived (slaveDataReceived),
    .rxValid           (rxValid),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts clk cycles with rxValid high, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (rxValid === 1'b1) rx_pulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors_applied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    for (int j = 0; j < n; j++) @(negedge clk);
  endtask

  task automatic pulseLoad(input logic [7:0] word);
    slaveDataToSend = word;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // load_at: bit index to pulse load during, -2 to pulse it in the cycle the CS fall is seen, -1 none.
  task automatic applyStimulus(input logic [15:0] mosi_word, input int nbits, input int load_at,
                               input logic [7:0] load_word, output logic [15:0] miso_word,
                               output int latency, output logic busy_end);
    miso_word = '0;
    latency   = 0;
    CS = 1'b0;
    for (int j = 1; j <= HALF; j++) begin
      @(negedge clk);
      if (load_at == -2 && j == 2) begin
        slaveDataToSend = load_word;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    for (int i = 0; i < nbits; i++) begin
      MOSI = mosi_word[i];
      SCLK = 1'b1;
      if (load_at == i) begin
        slaveDataToSend = load_word;
        load = 1'b1;
      end
      for (int j = 1; j <= HALF; j++) begin
        @(negedge clk);
        load = 1'b0;
      end
      miso_word[i] = MISO;
      SCLK = 1'b0;
      for (int j = 1; j <= HALF; j++) begin
        @(negedge clk);
        if (rxValid === 1'b1 && latency == 0) latency = j;
      end
    end
    waitCycles(HALF);
    busy_end = busy;
    CS = 1'b1;
    waitCycles(HALF);
  endtask

  logic [15:0] miso_word;
  int          latency;
  logic        busy_end;
  int          p0;

  initial begin
    reset = 1'b0;
    SCLK = 1'b0;
    CS = 1'b1;
    MOSI = 1'b0;
    load = 1'b0;
    slaveDataToSend = 8'h00;
    waitCycles(3);
    checkOutput("reset_data", {24'b0, slaveDataReceived}, 32'h00);
    checkOutput("reset_rxvalid", {31'b0, rxValid}, 32'h0);
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("reset_miso", {31'b0, MISO}, {31'b0, MISO_IDLE});
    reset = 1'b1;
    waitCycles(HALF);

    // Basic frame: transmit 0xA5 while receiving 0x3C
    pulseLoad(8'hA5);
    checkOutput("idle_miso", {31'b0, MISO}, {31'b0, MISO_IDLE});
    p0 = rx_pulses;
    applyStimulus(16'h003C, 8, -1, 8'h00, miso_word, latency, busy_end);
    checkOutput("f1_miso", {24'b0, miso_word[7:0]}, 32'hA5);
    checkOutput("f1_data", {24'b0, slaveDataReceived}, 32'h3C);
    checkOutput("f1_pulses", rx_pulses - p0, 32'd1);
    checkOutput("f1_latency", latency, 32'd4);
    checkOutput("f1_busy_done", {31'b0, busy_end}, 32'h1);
    checkOutput("f1_busy_after", {31'b0, busy}, 32'h0);

    // SCLK toggling while idle is ignored
    p0 = rx_pulses;
    for (int k = 0; k < 3; k++) begin
      SCLK = 1'b1;
      waitCycles(HALF);
      SCLK = 1'b0;
      waitCycles(HALF);
    end
    checkOutput("idle_sclk_busy", {31'b0, busy}, 32'h0);
    checkOutput("idle_sclk_pulses", rx_pulses - p0, 32'd0);

    // Abort after 5 bits
    p0 = rx_pulses;
    applyStimulus(16'h0015, 5, -1, 8'h00, miso_word, latency, busy_end);
    checkOutput("abort_miso", {27'b0, miso_word[4:0]}, 32'h05);
    checkOutput("abort_pulses", rx_pulses - p0, 32'd0);
    checkOutput("abort_data", {24'b0, slaveDataReceived}, 32'h3C);
    checkOutput("abort_busy", {31'b0, busy}, 32'h0);
    p0 = rx_pulses;
    applyStimulus(16'h00FF, 8, -1, 8'h00, miso_word, latency, busy_end);
    checkOutput("post_abort_miso", {24'b0, miso_word[7:0]}, 32'hA5);
    checkOutput("post_abort_data", {24'b0, slaveDataReceived}, 32'hFF);
    checkOutput("post_abort_pulses", rx_pulses - p0, 32'd1);

    // Load 0x11 mid-frame, then two back-to-back frames reuse it
    applyStimulus(16'h0042, 8, 3, 8'h11, miso_word, latency, busy_end);
    checkOutput("midload_miso", {24'b0, miso_word[7:0]}, 32'hA5);
    checkOutput("midload_data", {24'b0, slaveDataReceived}, 32'h42);
    p0 = rx_pulses;
    applyStimulus(16'h0001, 8, -1, 8'h00, miso_word, latency, busy_end);
    checkOutput("b2b1_miso", {24'b0, miso_word[7:0]}, 32'h11);
    checkOutput("b2b1_data", {24'b0, slaveDataReceived}, 32'h01);
    applyStimulus(16'h0080, 8, -1, 8'h00, miso_word, latency, busy_end);
    checkOutput("b2b2_miso", {24'b0, miso_word[7:0]}, 32'h11);
    checkOutput("b2b2_data", {24'b0, slaveDataReceived}, 32'h80);
    checkOutput("b2b_pulses", rx_pulses - p0, 32'd2);

    // Load coincident with CS fall, plus a ninth SCLK pulse landing in DONE
    p0 = rx_pulses;
    applyStimulus(16'h01C3, 9, -2, 8'h6C, miso_word, latency, busy_end);
    checkOutput("csload_miso", {24'b0, miso_word[7:0]}, 32'h6C);
    checkOutput("extra_sclk_data", {24'b0, slaveDataReceived}, 32'hC3);
    checkOutput("extra_sclk_pulses", rx_pulses - p0, 32'd1);

    // Reset after 3 bits of a frame
    CS = 1'b0;
    waitCycles(HALF);
    for (int i = 0; i < 3; i++) begin
      MOSI = 1'b1;
      SCLK = 1'b1;
      waitCycles(HALF);
      SCLK = 1'b0;
      waitCycles(HALF);
    end
    reset = 1'b0;
    CS = 1'b1;
    MOSI = 1'b0;
    #1;
    checkOutput("midrst_data", {24'b0, slaveDataReceived}, 32'h00);
    checkOutput("midrst_rxvalid", {31'b0, rxValid}, 32'h0);
    checkOutput("midrst_busy", {31'b0, busy}, 32'h0);
    checkOutput("midrst_miso", {31'b0, MISO}, {31'b0, MISO_IDLE});
    waitCycles(2);
    reset = 1'b1;
    waitCycles(HALF);
    checkOutput("post_rst_busy", {31'b0, busy}, 32'h0);
    p0 = rx_pulses;
    applyStimulus(16'h005A, 8, -1, 8'h00, miso_word, latency, busy_end);
    checkOutput("post_rst_miso", {24'b0, miso_word[7:0]}, 32'h00);
    checkOutput("post_rst_data", {24'b0, slaveDataReceived}, 32'h5A);
    checkOutput("post_rst_pulses", rx_pulses - p0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 DATA_WIDTH, 8, frame length in bits and width of both data ports.
REQ-002 SYNC_STAGES, 2, flip-flop depth of each input synchronizer; legal range 2-3.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 SCLK  input  1  serial clock from master; idles low.
REQ-006 CS  input  1  chip select, active-low.
REQ-007 MOSI  input  1  serial data from master.
REQ-008 MISO  output  1  serial data to master.
REQ-009 slaveDataToSend  input  DATA_WIDTH  next transmit word.
REQ-010 load  input  1  one-cycle strobe; captures slaveDataToSend into the transmit buffer.
REQ-011 slaveDataReceived  output  DATA_WIDTH  last complete received word.
REQ-012 rxValid  output  1  one-cycle pulse; a new word is available.
REQ-013 busy  output  1  high while a frame is in progress.

Function
REQ-014 SCLK, CS and MOSI SHALL each pass through a SYNC_STAGES synchronizer, then one edge-detect register; all edge events SHALL be derived from the synchronized copies.
REQ-015 The bit order SHALL be LSB first in both directions.
REQ-016 The FSM SHALL have the states IDLE, SHIFT and DONE; the reset state SHALL be IDLE.
REQ-017 IDLE->SHIFT on a synchronized CS falling edge: copy the transmit buffer to the shift register, clear bitCount to 0, and drive MISO with bit 0.
REQ-018 In SHIFT, each synchronized SCLK falling edge SHALL shift synchronized MOSI into the MSB of the receive shift register (shift right), present the next transmit bit on MISO, and increment bitCount.
REQ-019 When bitCount reaches DATA_WIDTH, SHIFT->DONE: in the same cycle, load slaveDataReceived from the receive shift register and pulse rxValid for exactly one clk cycle.
REQ-020 DONE->IDLE on a synchronized CS rising edge.
REQ-021 SCLK edges in DONE SHALL be ignored; a frame is exactly DATA_WIDTH bits.
REQ-022 A CS rising edge in SHIFT SHALL abort the frame: return to IDLE, no rxValid, slaveDataReceived unchanged.
REQ-023 SCLK edges while in IDLE SHALL be ignored.
REQ-024 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-025 load SHALL update the transmit buffer in any state; a load during a frame SHALL NOT affect the frame in flight and SHALL apply from the next CS fall.
REQ-026 Without a load, the transmit buffer SHALL retain its value, so the same word is resent.
REQ-027 If load and a CS falling edge are detected in the same cycle, the new slaveDataToSend SHALL be the word transmitted.
REQ-028 Latency: 1 + SYNC_STAGES + 1 clk cycles from the 8th SCLK pin fall to rxValid high.
REQ-029 The master SHALL hold SCLK high and low each for at least SYNC_STAGES+2 clk periods; behaviour outside this is undefined.

Reset
REQ-030 While reset=0, asynchronously: state=IDLE, bitCount=0, shift registers=0, transmit buffer=0, synchronizers=idle (SCLK 0, CS 1, MOSI 0), slaveDataReceived=0, rxValid=0, busy=0, MISO=0 (or Z per REQ-033).
REQ-031 Reset asserted mid-frame SHALL discard the frame; after release, the block SHALL wait for a fresh CS falling edge.

Configuration
REQ-032 Macro SPI_SLAVE_MISO_TRISTATE_EN selects the MISO drive behaviour.
REQ-033 Defined: MISO SHALL be high-impedance whenever synchronized CS=1 or the state is IDLE. Undefined: MISO SHALL drive 0 in those conditions. Driven behaviour in SHIFT and DONE is identical in both builds.

Verification
REQ-034 load 0xA5, one 8-bit frame with MOSI carrying 0x3C LSB first -> MISO sequence 1,0,1,0,0,1,0,1; slaveDataReceived=0x3C; one rxValid pulse.
REQ-035 CS raised after 5 SCLK falls -> no rxValid; slaveDataReceived keeps its prior value; busy returns 0; the next full frame with MOSI=0xFF yields 0xFF.
REQ-036 load 0x11 mid-frame while 0xA5 is transmitting -> current frame shifts 0xA5; the next frame shifts 0x11.
REQ-037 Two back-to-back frames (0x01, then 0x80) without a new load -> both frames transmit the same buffer word; rxValid pulses twice; final slaveDataReceived=0x80.
REQ-038 reset pulsed low after 3 bits -> all outputs at reset values immediately; the following full frame with MOSI=0x5A yields 0x5A.
REQ-039 Run both builds, with and without SPI_SLAVE_MISO_TRISTATE_EN -> MISO reads Z (defined) or 0 (undefined) while CS=1.
